key_seq_player: RTL
===================

KEY_SEQ_PLAYER -- requirements
Module: key_seq_player

Interface
REQ-001 Parameter HOLD_CYC, default 16: cycles each key is held pressed (legal range 1..255).
REQ-002 Parameter GAP_CYC, default 16: all-released cycles after each key (legal range 1..255).
REQ-003 Port clock  input  1  sole clock; all state on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  single-cycle request to play code_in.
REQ-006 Port abort  input  1  stop playback immediately.
REQ-007 Port code_in  input  16  four key indices (0..11), nibble [15:12] played first.
REQ-008 Port Key  output  12  virtual keypad lines, one-hot or zero, same format as the keypad Key bus.
REQ-009 Port busy  output  1  playback in progress.
REQ-010 Port done  output  1  one-cycle pulse on completed playback.
REQ-011 Port err  output  1  one-cycle pulse on a rejected start.

Function
REQ-012 States: IDLE, PRESS, GAP, DONE; the FSM is registered and all outputs are registered.
REQ-013 In IDLE, start=1 with every nibble <=11 captures code_in, clears the digit index, and enters PRESS on the next edge.
REQ-014 In IDLE, start=1 with any nibble >11 keeps the FSM in IDLE, keeps Key=0, and pulses err for exactly one cycle, starting on the next cycle.
REQ-015 In PRESS, Key[d]=1 for current digit d and all other bits are 0, for exactly HOLD_CYC cycles; the FSM then enters GAP.
REQ-016 In GAP, Key=0 for exactly GAP_CYC cycles; the FSM then returns to PRESS for the next digit, or enters DONE after the last digit.
REQ-017 Timing, with start sampled at edge k: the first press is visible in cycles k+1..k+HOLD_CYC, and done=1 in cycle k+N*(HOLD_CYC+GAP_CYC)+1, where N is the number of keys played; DONE lasts one cycle and then returns to IDLE.
REQ-018 busy=1 exactly while the FSM is in PRESS or GAP; busy=0 in the DONE cycle.
REQ-019 start while busy=1 is ignored: no err, no restart, and the captured code is unchanged.
REQ-020 abort=1 in PRESS or GAP forces IDLE on the next edge, with Key=0, busy=0 and no done; abort in IDLE or DONE has no effect.
REQ-021 If start and abort are both high in IDLE, start wins.
REQ-022 The hold/gap counter is $clog2(256) bits wide, counts up from 0, and is cleared on every state change; the digit index wraps nowhere, because playback always terminates.
REQ-023 Key never has more than one bit set in any cycle, and is never set in two consecutive keys without at least GAP_CYC zero cycles between them.

Reset
REQ-024 While reset is high, state=IDLE, Key=12'h000, busy=0, done=0, err=0, the counter is 0, and the captured code is 0.
REQ-025 Asserting reset mid-PRESS clears Key asynchronously within the same cycle; after reset is released, no playback resumes.

Configuration
REQ-026 Macro KEY_SEQ_TERM_EN: when defined, a terminator key index 11 ('#') is played after the four digits, so N=5.
REQ-027 When KEY_SEQ_TERM_EN is undefined, N=4 and no terminator logic is present.

Structure
REQ-028 Package key_seq_pkg holds the state enum, KEY_W=12, DIGIT_W=4, NUM_DIGITS=4 and TERM_KEY=11.
REQ-029 Sub-module key_onehot (4-bit index in, 12-bit one-hot out, zero for indices >11) is instantiated once to drive Key.

Verification (defaults HOLD_CYC=16, GAP_CYC=16)
REQ-030 start with code_in=16'h1234 -> Key=12'h002 for 16 cycles, 0 for 16, 12'h004, 12'h008, 12'h010 in turn; done in cycle k+129.
REQ-031 start with code_in=16'h1C00 -> err high for one cycle, Key stays 0, busy stays 0.
REQ-032 Second start with 16'h9999 at cycle k+40 during 16'h1234 playback -> ignored; the sequence and done timing match REQ-030.
REQ-033 abort at cycle k+20 (first gap) -> Key=0 and busy=0 from k+21, and no done is ever pulsed; reset asserted mid-PRESS -> Key=0 immediately.
REQ-034 With KEY_SEQ_TERM_EN, code 16'h0000 -> four presses of 12'h001, then 12'h800; done in cycle k+161.

Source files
------------

// File: rtl/key_seq_pkg.sv
// key_seq_pkg: shared types, widths and code helpers for the key sequence player.
package key_seq_pkg;
  typedef enum logic [1:0] {IDLE, PRESS, GAP, DONE} state_t;
  localparam int KEY_W = 12;
  localparam int DIGIT_W = 4;
  localparam int NUM_DIGITS = 4;
  localparam int TERM_KEY = 11;
  function automatic logic code_ok(input logic [15:0] c);
    return c[15:12] <= DIGIT_W'(KEY_W - 1) && c[11:8] <= DIGIT_W'(KEY_W - 1) &&
           c[7:4] <= DIGIT_W'(KEY_W - 1) && c[3:0] <= DIGIT_W'(KEY_W - 1);
  endfunction
  function automatic logic [DIGIT_W-1:0] nibble_at(input logic [15:0] c, input logic [1:0] i);
    return i == 2'd0 ? c[15:12] : i == 2'd1 ? c[11:8] : i == 2'd2 ? c[7:4] : c[3:0];
  endfunction
endpackage

// File: rtl/key_onehot.sv
// key_onehot: key index to one-hot keypad lines; indices above 11 give all-zero.
module key_onehot
  import key_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] idx,
  output logic [KEY_W-1:0]   onehot
);
  assign onehot = idx < DIGIT_W'(KEY_W) ? KEY_W'(1) << idx : '0;
endmodule

// File: rtl/key_seq_player.sv
// key_seq_player: plays a 4-key code as timed virtual key presses.
// Defining KEY_SEQ_TERM_EN appends a '#' (index 11) terminator press.
module key_seq_player
  import key_seq_pkg::*;
#(
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      code_in,
  output logic [KEY_W-1:0] Key,
  output logic             busy,
  output logic             done,
  output logic             err
);
`ifdef KEY_SEQ_TERM_EN
  localparam int N_KEYS = NUM_DIGITS + 1;
`else
  localparam int N_KEYS = NUM_DIGITS;
`endif
  state_t state, state_n;
  logic [$clog2(256)-1:0] cnt, cnt_n;
  logic [2:0] digit, digit_n;
  logic [15:0] code, code_n;
  logic err_n;
  logic [DIGIT_W-1:0] key_idx;
  logic [KEY_W-1:0] key_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 8'd1;
    digit_n = digit;
    code_n = code;
    err_n = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (start && code_ok(code_in)) begin
          state_n = PRESS;
          code_n = code_in;
          digit_n = '0;
        end else if (start) begin
          err_n = 1'b1;
        end
      end
      PRESS: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n = '0;
        end else if (cnt == 8'(HOLD_CYC - 1)) begin
          state_n = GAP;
          cnt_n = '0;
        end
      end
      GAP: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n = '0;
        end else if (cnt == 8'(GAP_CYC - 1)) begin
          state_n = digit == 3'(N_KEYS - 1) ? DONE : PRESS;
          digit_n = digit + 3'd1;
          cnt_n = '0;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  // outputs are registered from the next state so the first press shows right after the start edge
`ifdef KEY_SEQ_TERM_EN
  assign key_idx = state_n != PRESS ? '1 :
                   digit_n == 3'(NUM_DIGITS) ? DIGIT_W'(TERM_KEY) : nibble_at(code_n, digit_n[1:0]);
`else
  assign key_idx = state_n != PRESS ? '1 : nibble_at(code_n, digit_n[1:0]);
`endif
  key_onehot u_onehot (.idx(key_idx), .onehot(key_n));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      digit <= '0;
      code <= '0;
      Key <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      digit <= digit_n;
      code <= code_n;
      Key <= key_n;
      busy <= state_n == PRESS || state_n == GAP;
      done <= state_n == DONE;
      err <= err_n;
    end
  end
endmodule
